// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline-stage register with two-entry skid buffer
//
// Carries a control bundle, NUM_DATA data lanes and a destination-register
// field across a pipeline boundary with valid/ready handshaking on both sides.
// Flush squashes every held and incoming entry; a squashed entry never shows
// non-zero control bits downstream.
//
// Optional build macro: PIPE_STAGE_PERF_EN adds StallCount/DropCount outputs.
//
// Ports:
//   Clk        rising-edge clock
//   Reset      asynchronous, active-high reset
//   Flush      synchronous squash of held and incoming entries
//   inValid    upstream offers an entry
//   inReady    stage can accept (decoded from state only)
//   inCtrl     control bundle in
//   inData     NUM_DATA lanes packed, lane 0 in LSBs
//   inReg      destination register in
//   outValid   entry presented downstream (decoded from state only)
//   outReady   downstream accepts
//   outCtrl    control out, forced to 0 while outValid=0
//   outData    data lanes out, held while invalid
//   outReg     destination register out, held while invalid
//   StallCount cycles with outValid=1 and outReady=0, saturating (perf build)
//   DropCount  entries discarded by Flush, saturating (perf build)
module pipe_stage_skid #(
    parameter int CTRL_W   = 4,
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 4,
    parameter int REG_W    = 5
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Flush,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [CTRL_W-1:0]          inCtrl,
    input  logic [NUM_DATA*DATA_W-1:0] inData,
    input  logic [REG_W-1:0]           inReg,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [CTRL_W-1:0]          outCtrl,
    output logic [NUM_DATA*DATA_W-1:0] outData,
    output logic [REG_W-1:0]           outReg
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]                StallCount,
    output logic [31:0]                DropCount
`endif
);

    localparam int LANES_W = NUM_DATA * DATA_W;
    localparam int PAY_W   = CTRL_W + LANES_W + REG_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [PAY_W-1:0]   mainQ;
    logic [PAY_W-1:0]   skidQ;
    logic [PAY_W-1:0]   inPayload;
    logic               accept;
    logic               release_;
    logic               loadMainIn;
    logic               loadMainSkid;
    logic               loadSkid;

    assign inPayload = {inCtrl, inData, inReg};

    // Both handshake outputs are pure decodes of the state register, so
    // neither depends combinationally on inValid or outReady.
    assign inReady  = (state != TWO);
    assign outValid = (state != EMPTY);
    assign accept   = inValid & inReady;
    assign release_ = outValid & outReady;

    always_comb begin
        stateNext    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        if (Flush) begin
            // Any release this cycle has already been sampled downstream;
            // everything else, including a same-cycle accept, is dropped.
            stateNext = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        loadMainIn = 1'b1;
                        stateNext  = ONE;
                    end
                end
                ONE: begin
                    if (accept && release_) begin
                        loadMainIn = 1'b1;
                    end else if (accept) begin
                        loadSkid  = 1'b1;
                        stateNext = TWO;
                    end else if (release_) begin
                        stateNext = EMPTY;
                    end
                end
                TWO: begin
                    if (release_) begin
                        loadMainSkid = 1'b1;
                        stateNext    = ONE;
                    end
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= EMPTY;
            mainQ <= '0;
            skidQ <= '0;
        end else begin
            state <= stateNext;
            if (loadMainIn) begin
                mainQ <= inPayload;
            end else if (loadMainSkid) begin
                mainQ <= skidQ;
            end
            if (loadSkid) begin
                skidQ <= inPayload;
            end
        end
    end

    assign outCtrl = mainQ[PAY_W-1 -: CTRL_W] & {CTRL_W{outValid}};
    assign outData = mainQ[REG_W +: LANES_W];
    assign outReg  = mainQ[REG_W-1:0];

`ifdef PIPE_STAGE_PERF_EN
    logic [1:0]  heldCnt;
    logic [1:0]  dropAdd;
    logic [32:0] dropSum;

    // Held entries minus one released this cycle, plus a same-cycle accept.
    // In TWO no accept is possible, so the result never exceeds 2.
    assign heldCnt = (state == TWO) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);
    assign dropAdd = heldCnt - {1'b0, release_} + {1'b0, accept};
    assign dropSum = {1'b0, DropCount} + {31'b0, dropAdd};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            StallCount <= '0;
            DropCount  <= '0;
        end else begin
            if (outValid && !outReady && (StallCount != 32'hFFFF_FFFF)) begin
                StallCount <= StallCount + 32'd1;
            end
            if (Flush) begin
                DropCount <= dropSum[32] ? 32'hFFFF_FFFF : dropSum[31:0];
            end
        end
    end
`endif

endmodule
